multicycle_add_sub: RTL



---
 rtl/multicycle_add_sub.sv | 117 +++++++++++
 1 files changed

// File: rtl/multicycle_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor. It processes one CHUNK-bit slice per
// clock, so only a CHUNK-bit carry chain is needed. Valid/ready handshakes on both sides.
module multicycle_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [WIDTH-1:0]  r_s;
  logic              r_carry;
  logic              r_c_out;
  logic              r_ovf;
  logic [IDX_W-1:0]  r_idx;

  logic [BASE_W-1:0] w_base;
  logic [CHUNK-1:0]  w_slice_a;
  logic [CHUNK-1:0]  w_slice_b;
  logic [CHUNK:0]    w_slice_sum;
  logic              w_last;
  logic              w_accept;

  // Handshake outputs come straight from the state register, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign s         = r_s;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_base   = BASE_W'(32'(r_idx) * CHUNK);

  assign w_slice_a   = r_op_a[w_base +: CHUNK];
  assign w_slice_b   = r_op_b[w_base +: CHUNK];
  assign w_slice_sum = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {{CHUNK{1'b0}}, r_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first means every path drives w_state_nxt,
  // so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1; the +1 enters as the first carry-in.
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_s[w_base +: CHUNK] <= w_slice_sum[CHUNK-1:0];
      r_carry              <= w_slice_sum[CHUNK];
      if (w_last) begin
        r_idx   <= '0;
        r_c_out <= w_slice_sum[CHUNK];
        r_ovf   <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                   (w_slice_sum[CHUNK-1] != r_op_a[WIDTH-1]);
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

endmodule
